// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the CPU M-stage port, the debug/loader master and dmem.
// The arbiter uses the slave view; the surrounding environment uses the master view.
`timescale 1ns/1ps
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [1:0]    cpu_size;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [1:0]    dbg_size;
    logic          dbg_gnt;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_rvalid;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_be;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_size,
        output dbg_gnt, dbg_rdata, dbg_rvalid,
        output mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_size,
        input  dbg_gnt, dbg_rdata, dbg_rvalid,
        input  mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single dmem port between the CPU M-stage and the debug master,
// with a starvation counter that bounds how long debug can be held off.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   CPU_PRI  | CPU wins any conflict; debug only gets idle cycles
//   DBG_PRI  | debug has waited long enough and wins the next conflict
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_TC  = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

    typedef enum logic {
        CPU_PRI = 1'b0,
        DBG_PRI = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    state_t        state, state_nxt;
    owner_t        rd_owner, owner_nxt;
    logic [CW-1:0] wait_cnt, wait_nxt;
    logic          cpu_gnt, dbg_gnt;
    logic          mux_we;
    logic [AW-1:0] mux_addr;
    logic [DW-1:0] mux_wdata;
    logic [1:0]    mux_be;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= CPU_PRI;
            wait_cnt <= '0;
            rd_owner <= OWN_NONE;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            rd_owner <= owner_nxt;
        end
    end

    always_comb begin
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        owner_nxt = OWN_NONE;

        // No access is issued while reset is held, so dmem never sees a stray write.
        if (reset) begin
            if (state == DBG_PRI && bus.dbg_req) begin
                dbg_gnt = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (bus.dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end

        if (!bus.dbg_req || dbg_gnt) begin
            wait_nxt = '0;
        end else if (wait_cnt != WAIT_SAT) begin
            wait_nxt = wait_cnt + 1'b1;
        end

        case (state)
            CPU_PRI: begin
                if (bus.dbg_req && !dbg_gnt && wait_cnt == WAIT_TC) begin
                    state_nxt = DBG_PRI;
                end
            end
            DBG_PRI: begin
                if (dbg_gnt || !bus.dbg_req) begin
                    state_nxt = CPU_PRI;
                end
            end
            default: state_nxt = CPU_PRI;
        endcase

        if (cpu_gnt && !bus.cpu_we) begin
            owner_nxt = OWN_CPU;
        end else if (dbg_gnt && !bus.dbg_we) begin
            owner_nxt = OWN_DBG;
        end
    end

    always_comb begin
        mux_we    = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        mux_be    = 2'b00;
        if (cpu_gnt) begin
            mux_we    = bus.cpu_we;
            mux_addr  = bus.cpu_addr;
            mux_wdata = bus.cpu_wdata;
            mux_be    = bus.cpu_size;
        end else if (dbg_gnt) begin
            mux_we    = bus.dbg_we;
            mux_addr  = bus.dbg_addr;
            mux_wdata = bus.dbg_wdata;
            mux_be    = bus.dbg_size;
        end
    end

    assign bus.mem_we     = mux_we;
    assign bus.mem_addr   = mux_addr;
    assign bus.mem_wdata  = mux_wdata;
    assign bus.mem_be     = mux_be;

    assign bus.cpu_stall  = reset & bus.cpu_req & ~cpu_gnt;
    assign bus.dbg_gnt    = dbg_gnt;

    // Both masters see the raw read data; only the owner's rvalid qualifies it.
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dbg_rdata  = bus.mem_rdata;
    assign bus.cpu_rvalid = (rd_owner == OWN_CPU);
    assign bus.dbg_rvalid = (rd_owner == OWN_DBG);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected bus issues and read
// returns into queues, a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // dmem stand-in: 1-cycle read latency, data is a fixed pattern of the address.
    always @(posedge clk) bus.mem_rdata <= 32'hC0DE_0000 | {16'h0000, bus.mem_addr[15:0]};

    typedef struct packed {
        logic        who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  be;
    } iss_t;

    iss_t        iss_q[$];
    logic [31:0] cpu_rd_q[$];
    logic [31:0] dbg_rd_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: DUT presented output with nothing expected", name);
    endtask

    task automatic cpu_drv(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] s);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_size  = s;
    endtask

    task automatic dbg_drv(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] s);
        bus.dbg_req   = req;
        bus.dbg_we    = we;
        bus.dbg_addr  = a;
        bus.dbg_wdata = d;
        bus.dbg_size  = s;
    endtask

    task automatic exp_iss(input logic who, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] s);
        iss_t e;
        e.who   = who;
        e.we    = we;
        e.addr  = a;
        e.wdata = d;
        e.be    = s;
        iss_q.push_back(e);
    endtask

    task automatic idle();
        cpu_drv(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        dbg_drv(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every issued access and every read return.
    always @(negedge clk) begin
        iss_t e;
        if (reset && (bus.dbg_gnt || (bus.cpu_req && !bus.cpu_stall))) begin
            if (iss_q.size() == 0) begin
                unexpected("issue");
            end else begin
                e = iss_q.pop_front();
                chk("issue_who",   {31'b0, bus.dbg_gnt}, {31'b0, e.who});
                chk("issue_we",    {31'b0, bus.mem_we},  {31'b0, e.we});
                chk("issue_addr",  bus.mem_addr,         e.addr);
                chk("issue_wdata", bus.mem_wdata,        e.wdata);
                chk("issue_be",    {30'b0, bus.mem_be},  {30'b0, e.be});
            end
        end else begin
            chk("idle_mem_we",   {31'b0, bus.mem_we}, 32'h0);
            chk("idle_mem_addr", bus.mem_addr,        32'h0);
        end
        if (bus.cpu_rvalid) begin
            if (cpu_rd_q.size() == 0) unexpected("cpu_rvalid");
            else chk("cpu_rdata", bus.cpu_rdata, cpu_rd_q.pop_front());
        end
        if (bus.dbg_rvalid) begin
            if (dbg_rd_q.size() == 0) unexpected("dbg_rvalid");
            else chk("dbg_rdata", bus.dbg_rdata, dbg_rd_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with both masters requesting: nothing may be issued or stalled.
        reset = 1'b0;
        cpu_drv(1'b1, 1'b1, 32'h55, 32'h66, 2'b10);
        dbg_drv(1'b1, 1'b1, 32'h77, 32'h88, 2'b00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_cpu_stall",  {31'b0, bus.cpu_stall},  32'h0);
            chk("rst_mem_we",     {31'b0, bus.mem_we},     32'h0);
            chk("rst_dbg_gnt",    {31'b0, bus.dbg_gnt},    32'h0);
            chk("rst_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'h0);
            chk("rst_dbg_rvalid", {31'b0, bus.dbg_rvalid}, 32'h0);
            next_cycle();
        end
        reset = 1'b1;
        idle();

        // CPU read @0x10
        cpu_drv(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
        exp_iss(1'b0, 1'b0, 32'h10, 32'h0, 2'b10);
        cpu_rd_q.push_back(32'hC0DE_0010);
        @(negedge clk);
        chk("t1_cpu_stall", {31'b0, bus.cpu_stall}, 32'h0);
        chk("t1_mem_addr",  bus.mem_addr,           32'h10);
        next_cycle();
        idle();
        @(negedge clk);
        chk("t1_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'h1);
        chk("t1_dbg_rvalid", {31'b0, bus.dbg_rvalid}, 32'h0);
        next_cycle();

        // Debug word write, uncontended
        dbg_drv(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 2'b10);
        exp_iss(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 2'b10);
        @(negedge clk);
        chk("t2_dbg_gnt", {31'b0, bus.dbg_gnt}, 32'h1);
        chk("t2_mem_we",  {31'b0, bus.mem_we},  32'h1);
        chk("t2_mem_be",  {30'b0, bus.mem_be},  32'h2);
        next_cycle();
        idle();
        @(negedge clk);
        chk("t2_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'h0);
        chk("t2_dbg_rvalid", {31'b0, bus.dbg_rvalid}, 32'h0);
        next_cycle();

        // Continuous conflict: debug must win on cycle 9 exactly
        cpu_drv(1'b1, 1'b0, 32'h40, 32'h0, 2'b10);
        dbg_drv(1'b1, 1'b0, 32'h80, 32'h0, 2'b10);
        for (int c = 1; c <= 9; c++) begin
            if (c < 9) begin
                exp_iss(1'b0, 1'b0, 32'h40, 32'h0, 2'b10);
                cpu_rd_q.push_back(32'hC0DE_0040);
            end else begin
                exp_iss(1'b1, 1'b0, 32'h80, 32'h0, 2'b10);
                dbg_rd_q.push_back(32'hC0DE_0080);
            end
            @(negedge clk);
            chk($sformatf("t3_dbg_gnt_c%0d", c),   {31'b0, bus.dbg_gnt},   {31'b0, c == 9});
            chk($sformatf("t3_cpu_stall_c%0d", c), {31'b0, bus.cpu_stall}, {31'b0, c == 9});
            next_cycle();
        end
        dbg_drv(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        exp_iss(1'b0, 1'b0, 32'h40, 32'h0, 2'b10);
        cpu_rd_q.push_back(32'hC0DE_0040);
        @(negedge clk);
        chk("t3_after_stall", {31'b0, bus.cpu_stall}, 32'h0);
        next_cycle();
        idle();
        @(negedge clk);
        next_cycle();

        // Back-to-back reads by different masters
        cpu_drv(1'b1, 1'b0, 32'h4, 32'h0, 2'b10);
        exp_iss(1'b0, 1'b0, 32'h4, 32'h0, 2'b10);
        cpu_rd_q.push_back(32'hC0DE_0004);
        @(negedge clk);
        next_cycle();
        cpu_drv(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        dbg_drv(1'b1, 1'b0, 32'h8, 32'h0, 2'b10);
        exp_iss(1'b1, 1'b0, 32'h8, 32'h0, 2'b10);
        dbg_rd_q.push_back(32'hC0DE_0008);
        @(negedge clk);
        chk("t4_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'h1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("t4_dbg_rvalid",   {31'b0, bus.dbg_rvalid}, 32'h1);
        chk("t4_cpu_rvalid_0", {31'b0, bus.cpu_rvalid}, 32'h0);
        next_cycle();

        // Debug withdraws after 5 denied cycles; its wait count must restart
        cpu_drv(1'b1, 1'b1, 32'h100, 32'h1111_2222, 2'b01);
        dbg_drv(1'b1, 1'b0, 32'h200, 32'h0, 2'b10);
        for (int c = 1; c <= 5; c++) begin
            exp_iss(1'b0, 1'b1, 32'h100, 32'h1111_2222, 2'b01);
            @(negedge clk);
            chk($sformatf("t5_stall_c%0d", c),   {31'b0, bus.cpu_stall}, 32'h0);
            chk($sformatf("t5_dbg_gnt_c%0d", c), {31'b0, bus.dbg_gnt},   32'h0);
            next_cycle();
        end
        dbg_drv(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        exp_iss(1'b0, 1'b1, 32'h100, 32'h1111_2222, 2'b01);
        @(negedge clk);
        chk("t5_drop_stall", {31'b0, bus.cpu_stall}, 32'h0);
        next_cycle();
        exp_iss(1'b0, 1'b1, 32'h100, 32'h1111_2222, 2'b01);
        @(negedge clk);
        chk("t5_wait_cnt", 32'(dut.wait_cnt), 32'h0);
        chk("t5_state",    32'(dut.state),    32'h0);
        next_cycle();
        dbg_drv(1'b1, 1'b0, 32'h200, 32'h0, 2'b10);
        for (int c = 1; c <= 7; c++) begin
            exp_iss(1'b0, 1'b1, 32'h100, 32'h1111_2222, 2'b01);
            @(negedge clk);
            chk($sformatf("t5_re_stall_c%0d", c),   {31'b0, bus.cpu_stall}, 32'h0);
            chk($sformatf("t5_re_dbg_gnt_c%0d", c), {31'b0, bus.dbg_gnt},   32'h0);
            next_cycle();
        end
        idle();
        @(negedge clk);
        next_cycle();

        // Reset the cycle after a CPU read grant
        cpu_drv(1'b1, 1'b0, 32'h30, 32'h0, 2'b10);
        exp_iss(1'b0, 1'b0, 32'h30, 32'h0, 2'b10);
        cpu_rd_q.push_back(32'hC0DE_0030);
        @(negedge clk);
        chk("t6_grant_stall", {31'b0, bus.cpu_stall}, 32'h0);
        next_cycle();
        reset = 1'b0;
        cpu_drv(1'b1, 1'b1, 32'h34, 32'h99, 2'b10);
        dbg_drv(1'b1, 1'b1, 32'h38, 32'h77, 2'b10);
        @(negedge clk);
        chk("t6_rst_dbg_gnt",   {31'b0, bus.dbg_gnt},   32'h0);
        chk("t6_rst_mem_we",    {31'b0, bus.mem_we},    32'h0);
        chk("t6_rst_cpu_stall", {31'b0, bus.cpu_stall}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("t6_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'h0);
        chk("t6_dbg_rvalid", {31'b0, bus.dbg_rvalid}, 32'h0);
        chk("t6_wait_cnt",   32'(dut.wait_cnt),       32'h0);
        chk("t6_state",      32'(dut.state),          32'h0);
        next_cycle();
        reset = 1'b1;
        idle();
        @(negedge clk);
        next_cycle();

        chk("end_iss_q",    32'(iss_q.size()),    32'h0);
        chk("end_cpu_rd_q", 32'(cpu_rd_q.size()), 32'h0);
        chk("end_dbg_rd_q", 32'(dbg_rd_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
